mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one external memory port between the instruction-fetch path and the load/store path, so the processor can use a single unified memory.
- Grants one outstanding transaction at a time through a 3-state FSM.
- Latches the owner's request and returns read data with a one-cycle completion pulse.
- Raises a stall signal that freezes the ProgramCounter and register-file write while any access is in flight.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT_CYC, 16, BUSY cycles without mem_ack before abort (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_rvalid  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request; held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  one-cycle pulse: data request accepted
d_rvalid  out  1  one-cycle pulse: data access complete
d_rdata  out  DATA_W  load data; 0 for stores
mem_req  out  1  memory request, held until mem_ack sampled
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion, may arrive in the first mem_req cycle
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
stall  out  1  combinational: any requester waiting or any transaction owned
err  out  1  pulse with rvalid on timeout abort; tied 0 when feature off

Behaviour:
Reset (rst=0, async):
- FSM goes to IDLE.
- All outputs except stall are 0; stall = if_req | d_req.
- Round-robin pointer is set to prefer DATA.
- A transaction in flight is abandoned and mem_req drops immediately; no rvalid is issued for it.

FSM states: IDLE, BUSY_IF, BUSY_D.

IDLE:
- No request: stay in IDLE.
- Only d_req: go to BUSY_D.
- Only if_req: go to BUSY_IF.
- Both: go to the side the pointer prefers, then flip the pointer. The pointer flips only on contested grants.
- On the transition edge, latch addr/we/wdata (fetch forces we=0).

BUSY_x:
- First cycle: x_gnt=1 and mem_req=1; mem_* driven from the latches.
- mem_req stays high until mem_ack is sampled high.
- Requests are not re-arbitrated while BUSY. A requester must deassert req or present a new request after gnt.

Completion:
- At the edge where mem_ack=1 the FSM returns to IDLE. In the following cycle x_rvalid=1 and x_rdata = captured mem_rdata (0 on a store).
- rdata holds its value until the next completion for that side.

Timing:
- Request in cycle N: gnt and mem_req in N+1. With zero-wait memory, rvalid in N+2 and the next arbitration in N+2.
- Peak throughput is one transaction per 2 cycles.

Other rules:
- mem_ack while IDLE is ignored.
- mem_ack and x_req asserting together in the same cycle cannot double-grant, because arbitration happens only in IDLE.
- stall = if_req | d_req | (state != IDLE). stall is low in the rvalid cycle unless a new request is asserted.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined: an 8-bit wait counter clears on entry to BUSY and increments each BUSY cycle without mem_ack. When it reaches TIMEOUT_CYC:
  - mem_req drops;
  - the FSM returns to IDLE;
  - the owner gets rvalid=1, err=1, rdata=32'hDEADBEEF.
  - mem_ack arriving in the same cycle as the timeout wins and completes normally.
- Undefined: no counter; err is constant 0; a transaction waits indefinitely.

Decomposition:
Package mem_port_arb_pkg holds:
- state encoding (IDLE=2'd0, BUSY_IF=2'd1, BUSY_D=2'd2);
- owner encoding (OWN_IF=0, OWN_D=1);
- ABORT_DATA = 32'hDEADBEEF;
- timeout counter width (8).

One sub-module, mem_port_arb_rr: 2-way round-robin picker with inputs req[1:0] and advance, output grant[1:0], internal pointer register on the same clk/rst. The FSM and datapath latches stay in the top level.

Test Plan:
1. Reset: hold rst=0 with if_req=1 → all outputs 0, stall=1; release rst, next cycle if_gnt=1 and mem_req=1.
2. Zero-wait load: d_req, d_addr=0x100, mem_ack tied 1, mem_rdata=0x12345678 → d_gnt in N+1; d_rvalid in N+2 with d_rdata=0x12345678; mem_we=0 throughout.
3. Store with 3 wait states: d_we=1, d_addr=0x40, d_wdata=0xCAFEF00D, ack in the 4th mem_req cycle → mem_req high 4 cycles with addr/wdata stable; d_rvalid one cycle later with d_rdata=0.
4. Contention: if_req and d_req held continuously for 4 grants → grant order D, IF, D, IF; no two grants without an intervening rvalid.
5. Reset mid-transaction: assert rst in the 2nd wait cycle of a fetch → mem_req falls asynchronously; no if_rvalid; first fetch after release re-grants from the same if_addr.
6. MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, mem_ack stuck 0 → mem_req high for exactly 16 cycles; then rvalid=1, err=1, rdata=0xDEADBEEF; FSM back in IDLE.

Source files
------------

// File: rtl/mem_port_arb_pkg.sv
// Shared encodings and constants for the unified memory-port arbiter.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;
  localparam int unsigned TMO_CNT_W  = 8;

endpackage

// File: rtl/mem_port_arb_rr.sv
// Two-way round-robin picker; bit OWN_IF is fetch, bit OWN_D is data.
// The pointer moves only when both sides were requesting and advance is set.
module mem_port_arb_rr
  import mem_port_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q;  // 1 = data side preferred
  logic ptr_d;

  // Pick the single requester, or the preferred side on contention.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Flip preference only on a contested grant.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (&req)) ptr_d = ~ptr_q;
  end

  // Pointer register; reset prefers data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 1'b1;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Optional abort on a stuck memory: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              err
);

  arb_state_e        state_q, state_d;
  logic              if_gnt_q, if_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        rr_grant;
  logic              rr_adv;
  logic [DATA_W-1:0] done_data;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
`else
  // Keeps the timeout parameter referenced when the feature is compiled out.
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYC);
`endif

  mem_port_arb_rr u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({d_req, if_req}),
    .advance (rr_adv),
    .grant   (rr_grant)
  );

  // Stores complete with zero read data.
  assign done_data = we_q ? '0 : mem_rdata;

  // Next-state, latch and completion logic.
  always_comb begin
    state_d     = state_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rr_adv      = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        rr_adv    = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
        if (rr_grant[OWN_D]) begin
          state_d   = BUSY_D;
          d_gnt_d   = 1'b1;
          mem_req_d = 1'b1;
          we_d      = d_we;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
        end else if (rr_grant[OWN_IF]) begin
          state_d   = BUSY_IF;
          if_gnt_d  = 1'b1;
          mem_req_d = 1'b1;
          we_d      = 1'b0;
          addr_d    = if_addr;
          wdata_d   = '0;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_D) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = done_data;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = done_data;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == TMO_CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == BUSY_D) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = DATA_W'(ABORT_DATA);
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = DATA_W'(ABORT_DATA);
          end
        end else begin
          cnt_d = cnt_q + TMO_CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Wait counter and abort flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Freeze the pipeline while anyone waits or a transaction is owned.
  assign stall = if_req | d_req | (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an expected-completion queue.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall, err;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        side;  // 1 = data
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until a completion appears (bounded) and check it against the queue head.
  task automatic wait_rv(input int budget, input string tag);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (if_rvalid || d_rvalid) seen = 1'b1;
    end
    chk({tag, "_rvalid_seen"}, 64'(seen), 64'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_side"}, 64'(d_rvalid), 64'(e.side));
      chk({tag, "_one_side"}, 64'(if_rvalid & d_rvalid), 64'd0);
      chk({tag, "_rdata"}, 64'(e.side ? d_rdata : if_rdata), 64'(e.data));
      chk({tag, "_err"}, 64'(err), 64'(e.err));
    end
  endtask

  initial begin
    int         k;
    int         outst;
    int         hi;
    logic [3:0] order;

    // 1: reset with a fetch pending
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h200;
    tick(); tick();
    chk("rst_if_gnt", 64'(if_gnt), 64'd0);
    chk("rst_d_gnt", 64'(d_gnt), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_stall", 64'(stall), 64'd1);
    rst = 1'b1;
    tick();
    chk("t1_if_gnt", 64'(if_gnt), 64'd1);
    chk("t1_mem_req", 64'(mem_req), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h200);
    chk("t1_mem_we", 64'(mem_we), 64'd0);
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
    sb.push_back('{side: 1'b0, data: 32'hA5A5_0001, err: 1'b0});
    wait_rv(1, "t1");

    // 2: zero-wait load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; mem_rdata = 32'h1234_5678;
    tick();
    chk("t2_d_gnt", 64'(d_gnt), 64'd1);
    chk("t2_mem_req", 64'(mem_req), 64'd1);
    chk("t2_mem_we", 64'(mem_we), 64'd0);
    chk("t2_mem_addr", 64'(mem_addr), 64'h100);
    chk("t2_stall_busy", 64'(stall), 64'd1);
    d_req = 1'b0;
    sb.push_back('{side: 1'b1, data: 32'h1234_5678, err: 1'b0});
    wait_rv(1, "t2");
    chk("t2_stall_rvalid", 64'(stall), 64'd0);
    chk("t2_mem_we_end", 64'(mem_we), 64'd0);

    // 3: store with three wait states
    mem_ack = 1'b0; mem_rdata = 32'h7777_7777;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D;
    tick();
    chk("t3_d_gnt", 64'(d_gnt), 64'd1);
    d_req = 1'b0; d_we = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("t3_mem_req", 64'(mem_req), 64'd1);
      chk("t3_mem_we", 64'(mem_we), 64'd1);
      chk("t3_mem_addr", 64'(mem_addr), 64'h40);
      chk("t3_mem_wdata", 64'(mem_wdata), 64'hCAFE_F00D);
      chk("t3_no_rvalid", 64'(d_rvalid), 64'd0);
      if (c == 4) mem_ack = 1'b1;
      else        tick();
    end
    sb.push_back('{side: 1'b1, data: 32'h0, err: 1'b0});
    wait_rv(1, "t3");
    chk("t3_mem_req_low", 64'(mem_req), 64'd0);
    tick();
    chk("t3_rvalid_pulse", 64'(d_rvalid), 64'd0);
    chk("t3_rdata_hold", 64'(d_rdata), 64'd0);

    // 4: contention after reset, order D IF D IF
    rst = 1'b0; tick(); rst = 1'b1;
    mem_ack = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h500; d_addr = 32'h600;
    order = 4'b0101;
    k = 0; outst = 0;
    for (int i = 0; i < 20 && k < 4; i++) begin
      tick();
      if (if_rvalid || d_rvalid) outst--;
      if (if_gnt || d_gnt) begin
        chk("t4_one_outstanding", 64'(outst), 64'd0);
        chk("t4_gnt_order", 64'(d_gnt), 64'(order[k]));
        chk("t4_one_gnt", 64'(if_gnt & d_gnt), 64'd0);
        k++;
        outst++;
      end
    end
    chk("t4_gnt_count", 64'(k), 64'd4);
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();

    // 5: reset during the second wait cycle of a fetch
    mem_ack = 1'b0; if_req = 1'b1; if_addr = 32'h300;
    tick();
    chk("t5_if_gnt", 64'(if_gnt), 64'd1);
    tick(); tick();
    chk("t5_mem_req_wait", 64'(mem_req), 64'd1);
    rst = 1'b0;
    #1;
    chk("t5_mem_req_async", 64'(mem_req), 64'd0);
    chk("t5_stall_in_rst", 64'(stall), 64'd1);
    tick();
    chk("t5_no_rvalid", 64'(if_rvalid), 64'd0);
    rst = 1'b1;
    tick();
    chk("t5_regrant", 64'(if_gnt), 64'd1);
    chk("t5_regrant_addr", 64'(mem_addr), 64'h300);
    chk("t5_no_rvalid2", 64'(if_rvalid), 64'd0);
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    sb.push_back('{side: 1'b0, data: 32'h0BAD_F00D, err: 1'b0});
    wait_rv(1, "t5");

`ifdef MEM_ARB_TIMEOUT_EN
    // 6: memory never acknowledges
    mem_ack = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    tick();
    chk("t6_d_gnt", 64'(d_gnt), 64'd1);
    d_req = 1'b0;
    hi = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      hi++;
      if (mem_req) tick();
    end
    chk("t6_req_cycles", 64'(hi), 64'd16);
    chk("t6_rvalid", 64'(d_rvalid), 64'd1);
    chk("t6_err", 64'(err), 64'd1);
    chk("t6_rdata", 64'(d_rdata), 64'hDEAD_BEEF);
    chk("t6_idle", 64'(stall), 64'd0);
    tick();
    chk("t6_err_pulse", 64'(err), 64'd0);
`else
    hi = 0;
    chk("t6_err_off", 64'(err), 64'(hi));
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
